mux_scan_n: RTL and testbench

//  Parametrised, registered N-to-1 multiplexer for W-bit channels; successor to the 8-to-1 bit mux.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_sel_ctr.sv | 43 ++++
 rtl/mux_scan_n.sv | 72 +++++++
 tb/tb_mux_scan_n.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N-to-1 scan multiplexer.
package mux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_sel_ctr.sv
// Channel select register: software load with range check, round-robin advance with wrap pulse.
module mux_sel_ctr #(
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel_q,
    output logic             wrap,
    output logic             err
);
    localparam logic [SEL_W:0]   LIMIT = (SEL_W+1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_IN - 1);

    logic load_ok;
    assign load_ok = ({1'b0, load_val} < LIMIT);

    // A load, good or bad, always swallows that cycle's scan advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                if (load_ok) sel_q <= load_val;
                else         err   <= 1'b1;
            end else if (adv) begin
                if (sel_q == LAST) begin
                    sel_q <= '0;
                    wrap  <= 1'b1;
                end else begin
                    sel_q <= sel_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-to-1 channel funnel with valid/ready output; manual or round-robin select.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int W     = 1,
    parameter int SEL_W = clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              sel_load,
    input  logic [N_IN*W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              scan_wrap,
    output logic              sel_err
);
    state_t                  state_q, state_d;
    logic                    cap;
    logic [SEL_W-1:0]        sel_q;
    logic [N_IN-1:0][W-1:0]  ch;

    assign ch  = in_data;
    assign cap = en && (state_q == ST_EMPTY || out_ready);

    mux_sel_ctr #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (cap && (mode == MODE_SCAN)),
        .load     (sel_load),
        .load_val (sel_in),
        .sel_q    (sel_q),
        .wrap     (scan_wrap),
        .err      (sel_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (cap) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !en) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    assign out_valid = (state_q == ST_FULL);

    // Only written on cap, so data/index stay frozen while valid && !ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (cap) begin
            out_data <= ch[sel_q];
            out_sel  <= sel_q;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: 8x4-bit instance for most cases, 6x4-bit for range/wrap cases.
module tb_mux_scan_n;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A: N_IN=8, W=4
    logic        a_en, a_mode, a_load, a_ready;
    logic [2:0]  a_sel_in;
    logic [31:0] a_in;
    logic        a_valid, a_wrap, a_err;
    logic [3:0]  a_data;
    logic [2:0]  a_sel;

    // instance B: N_IN=6, W=4
    logic        b_en, b_mode, b_load, b_ready;
    logic [2:0]  b_sel_in;
    logic [23:0] b_in;
    logic        b_valid, b_wrap, b_err;
    logic [3:0]  b_data;
    logic [2:0]  b_sel;

    int n_chk = 0;
    int n_err = 0;

    mux_scan_n #(.N_IN(8), .W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .sel_in(a_sel_in),
        .sel_load(a_load), .in_data(a_in), .out_ready(a_ready), .out_valid(a_valid),
        .out_data(a_data), .out_sel(a_sel), .scan_wrap(a_wrap), .sel_err(a_err)
    );

    mux_scan_n #(.N_IN(6), .W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .sel_in(b_sel_in),
        .sel_load(b_load), .in_data(b_in), .out_ready(b_ready), .out_valid(b_valid),
        .out_data(b_data), .out_sel(b_sel), .scan_wrap(b_wrap), .sel_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [2:0] s, input logic [3:0] d);
        chk({tag, ".valid"}, 32'(a_valid), 32'(v));
        chk({tag, ".sel"},   32'(a_sel),   32'(s));
        chk({tag, ".data"},  32'(a_data),  32'(d));
    endtask

    initial begin
        // 1: reset with random inputs
        rst_n    = 1'b0;
        a_en     = 1'($urandom); a_mode = 1'($urandom); a_load = 1'($urandom);
        a_ready  = 1'($urandom); a_sel_in = 3'($urandom); a_in = $urandom;
        b_en     = 1'($urandom); b_mode = 1'($urandom); b_load = 1'($urandom);
        b_ready  = 1'($urandom); b_sel_in = 3'($urandom); b_in = 24'($urandom);
        tick(); tick();
        chk_a("rst", 1'b0, 3'd0, 4'h0);
        chk("rst.wrap", 32'(a_wrap), 32'd0);
        chk("rst.err",  32'(a_err),  32'd0);
        chk("rst.b_err", 32'(b_err), 32'd0);
        chk("rst.b_valid", 32'(b_valid), 32'd0);

        a_en = 1'b0; a_mode = 1'b1; a_load = 1'b0; a_ready = 1'b1; a_sel_in = 3'd0;
        b_en = 1'b0; b_mode = 1'b1; b_load = 1'b0; b_ready = 1'b1; b_sel_in = 3'd0;
        for (int k = 0; k < 8; k++) a_in[k*4 +: 4] = 4'(k + 8);
        for (int k = 0; k < 6; k++) b_in[k*4 +: 4] = 4'(k + 1);
        tick();
        rst_n = 1'b1;
        tick();

        // 2: scan at full throughput, wrap pulse with index 7
        a_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_a("scan", 1'b1, 3'(i % 8), 4'((i % 8) + 8));
            chk("scan.wrap", 32'(a_wrap), 32'((i % 8) == 7));
        end

        // 3: backpressure holds index 1, then resumes at 2
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("bp.hold", 1'b1, 3'd1, 4'd9);
        end
        a_en = 1'b0;
        tick();
        chk_a("bp.en0_hold", 1'b1, 3'd1, 4'd9);
        a_en = 1'b1; a_ready = 1'b1;
        tick();
        chk_a("bp.resume", 1'b1, 3'd2, 4'd10);

        // 4: manual load of 5; the loading capture still uses old select 3
        a_mode = 1'b0; a_load = 1'b1; a_sel_in = 3'd5; a_in[5*4 +: 4] = 4'hA;
        tick();
        chk_a("man.old", 1'b1, 3'd3, 4'd11);
        a_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("man.ch5", 1'b1, 3'd5, 4'hA);
        end
        a_in[5*4 +: 4] = 4'h3;
        tick();
        chk_a("man.ch5_new", 1'b1, 3'd5, 4'h3);
        chk("man.err", 32'(a_err), 32'd0);

        // 5: bad select on the 6-channel instance, then scan wraps 5->0
        b_load = 1'b1; b_sel_in = 3'd7;
        tick();
        b_load = 1'b0;
        chk("bad.err", 32'(b_err), 32'd1);
        chk("bad.valid", 32'(b_valid), 32'd0);
        b_load = 1'b1; b_sel_in = 3'd6;
        tick();
        b_load = 1'b0; b_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bad.sel",  32'(b_sel),  32'(i % 6));
            chk("bad.data", 32'(b_data), 32'((i % 6) + 1));
            chk("bad.wrap", 32'(b_wrap), 32'((i % 6) == 5));
        end
        chk("bad.sticky", 32'(b_err), 32'd1);
        b_en = 1'b0;

        // 6: collision - load 2 on the capture of index 4
        a_in[5*4 +: 4] = 4'd13;
        a_en = 1'b0; a_load = 1'b1; a_sel_in = 3'd4;
        tick();
        chk("col.drain", 32'(a_valid), 32'd0);
        a_mode = 1'b1; a_en = 1'b1; a_load = 1'b1; a_sel_in = 3'd2;
        tick();
        a_load = 1'b0;
        chk_a("col.cap4", 1'b1, 3'd4, 4'd12);
        chk("col.nowrap", 32'(a_wrap), 32'd0);
        tick();
        chk_a("col.next2", 1'b1, 3'd2, 4'd10);
        tick();
        chk_a("col.next3", 1'b1, 3'd3, 4'd11);

        // async reset mid-stream clears without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_a("arst", 1'b0, 3'd0, 4'h0);
        chk("arst.b_err", 32'(b_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_a("arst.first", 1'b1, 3'd0, 4'd8);
        tick();
        chk_a("arst.second", 1'b1, 3'd1, 4'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
